led_blinker: RTL and testbench

LED_BLINKER -- requirements
Module: led_blinker

---
 rtl/led_blinker_pkg.sv | 18 +
 rtl/led_blinker.sv | 95 +++++++++
 tb/tb_led_blinker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/led_blinker_pkg.sv
`default_nettype none
// =============================================================================
// led_blinker_pkg : shared state encoding for the LED blinker FSM.
// Revision 1.0
// =============================================================================
package led_blinker_pkg;

  localparam int NUM_STATES = 3;
  localparam int STATE_W    = $clog2(NUM_STATES);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_BLINK_ON  = 2'd1,
    ST_BLINK_OFF = 2'd2
  } state_e;

endpackage : led_blinker_pkg
`default_nettype wire

// File: rtl/led_blinker.sv
`default_nettype none
// =============================================================================
// led_blinker : square-wave LED blinker, HALF_PERIOD cycles lit then dark.
// Revision 1.0
// =============================================================================
module led_blinker
  import led_blinker_pkg::*;
#(
  parameter int HALF_PERIOD = 10,
  parameter int CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1
) (
  input  logic clk500hz,
  input  logic rst,
  input  logic LED1_on,
  output logic LED_blinkblink
);

  generate
    if (HALF_PERIOD < 1) begin : g_bad_half_period
      $fatal(1, "led_blinker: HALF_PERIOD must be at least 1");
    end
    if ((HALF_PERIOD > 1) && (CNT_W < $clog2(HALF_PERIOD))) begin : g_bad_cnt_w
      $fatal(1, "led_blinker: CNT_W too narrow for HALF_PERIOD");
    end
  endgenerate

  localparam logic [CNT_W-1:0] TERMINAL_CNT = CNT_W'(HALF_PERIOD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             w_terminal;

  assign w_terminal = (cnt_q == TERMINAL_CNT);

  // Disable dominates every state; the counter clears on each phase swap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!LED1_on) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLINK_ON;
          cnt_d   = '0;
        end
        ST_BLINK_ON: begin
          if (w_terminal) begin
            state_d = ST_BLINK_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLINK_OFF: begin
          if (w_terminal) begin
            state_d = ST_BLINK_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    led_d = (state_d == ST_BLINK_ON);
  end

  always_ff @(posedge clk500hz) begin
    if (rst) begin
      state_q <= ST_IDLE;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
    end
  end

  always_ff @(posedge clk500hz) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign LED_blinkblink = led_q;

endmodule : led_blinker
`default_nettype wire

// File: tb/tb_led_blinker.sv
`default_nettype none
// =============================================================================
// tb_led_blinker : directed scoreboard bench for led_blinker (HALF_PERIOD 10 and 1).
// Revision 1.0
// =============================================================================
module tb_led_blinker;
  import led_blinker_pkg::*;

  logic clk;
  logic rst;
  logic en;
  logic led10;
  logic led1;

  int n_compared;
  int n_mismatched;
  int cyc;

  typedef struct {
    logic exp10;
    bit   chk1;
    logic exp1;
    bit   chk_int;
  } exp_t;

  exp_t sb[$];
  exp_t m_item;

  led_blinker #(.HALF_PERIOD(10)) dut10 (
    .clk500hz       (clk),
    .rst            (rst),
    .LED1_on        (en),
    .LED_blinkblink (led10)
  );

  led_blinker #(.HALF_PERIOD(1)) dut1 (
    .clk500hz       (clk),
    .rst            (rst),
    .LED1_on        (en),
    .LED_blinkblink (led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the expectation is for the next rising edge.
  task automatic step(input logic r, input logic e, input logic x10,
                      input bit c1, input logic x1, input bit ci);
    exp_t it;
    @(negedge clk);
    rst = r;
    en  = e;
    it.exp10   = x10;
    it.chk1    = c1;
    it.exp1    = x1;
    it.chk_int = ci;
    sb.push_back(it);
  endtask

  task automatic run(input logic r, input logic e, input logic x10, input int n);
    for (int i = 0; i < n; i++) step(r, e, x10, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (sb.size() > 0) begin
      m_item = sb.pop_front();
      n_compared++;
      if (led10 !== m_item.exp10) begin
        n_mismatched++;
        $display("FAIL led10 cyc=%0d got=%b exp=%b", cyc, led10, m_item.exp10);
      end
      if (m_item.chk1) begin
        n_compared++;
        if (led1 !== m_item.exp1) begin
          n_mismatched++;
          $display("FAIL led1 cyc=%0d got=%b exp=%b", cyc, led1, m_item.exp1);
        end
      end
      if (m_item.chk_int) begin
        n_compared++;
        if ((dut10.state_q !== ST_IDLE) || (dut10.cnt_q !== 4'd0)) begin
          n_mismatched++;
          $display("FAIL idle_clear cyc=%0d got state=%0d cnt=%0d exp state=0 cnt=0",
                   cyc, dut10.state_q, dut10.cnt_q);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    cyc          = 0;
    rst          = 1'b1;
    en           = 1'b0;

    // Reset wins over enable, then first free edge lights the LED.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // 40 enabled cycles: 10 high, 10 low, 10 high, 10 low.
    run(1'b0, 1'b1, 1'b1, 10);
    run(1'b0, 1'b1, 1'b0, 10);
    run(1'b0, 1'b1, 1'b1, 10);
    run(1'b0, 1'b1, 1'b0, 10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Disable mid high phase, re-enable gets a fresh full high phase.
    run(1'b0, 1'b1, 1'b1, 5);
    run(1'b0, 1'b0, 1'b0, 5);
    run(1'b0, 1'b1, 1'b1, 10);
    run(1'b0, 1'b1, 1'b0, 2);

    // Disable during the low phase at cycle 15.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b1, 1'b1, 10);
    run(1'b0, 1'b1, 1'b0, 5);
    run(1'b0, 1'b0, 1'b0, 3);
    run(1'b0, 1'b1, 1'b1, 10);
    run(1'b0, 1'b1, 1'b0, 1);

    // Reset at cycle 7 of a high phase.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b1, 1'b1, 7);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b1, 1'b1, 10);
    run(1'b0, 1'b1, 1'b0, 1);

    // HALF_PERIOD=1 instance toggles every cycle while enabled.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, ((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_led_blinker
`default_nettype wire
